discharge_monitor: RTL
======================

DISCHARGE_MONITOR -- requirements
Module: discharge_monitor

Interface
REQ-001 SHALL have parameter BD_CUR, default 16'd15, meaning breakdown current threshold in A (sample_current >= BD_CUR).
REQ-002 SHALL have parameter BD_VOL, default 16'd30, meaning breakdown voltage threshold in V (sample_voltage <= BD_VOL).
REQ-003 SHALL have parameter SHORT_VOL, default 16'd5, meaning gap voltage in V at or below which a window start counts as short.
REQ-004 SHALL have parameter ARC_DELAY, default 16'd100, meaning breakdown delays below this many 10 ns ticks class as arc.
REQ-005 SHALL have ports: clk  in  1  100 MHz clock; rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports: is_machine  in  1  machining enabled; clear_stats  in  1  zero all counters.
REQ-007 SHALL have ports: mosfet_buck1  in  2  {top,bottom}; mosfet_res1  in  2  {top,bottom}; mosfet_deion  in  1  (monitored only, not used for classification).
REQ-008 SHALL have ports: sample_current, sample_voltage  in  17 each  signed samples.
REQ-009 SHALL have ports: pulse_valid  out  1  one-cycle strobe; pulse_class  out  2  00 open, 01 normal, 10 arc, 11 short; delay_time  out  16  breakdown delay in ticks.
REQ-010 SHALL have ports: open_cnt, normal_cnt, arc_cnt, short_cnt  out  16 each; short_alarm  out  1.

Function
REQ-011 SHALL define power_on = mosfet_buck1[1] | mosfet_res1[1], sampled each clk edge, with no input registering.
REQ-012 SHALL implement states IDLE, WAIT_BD, DISCHARGE, REPORT.
REQ-013 IDLE -> WAIT_BD on an edge with is_machine=1 and power_on=1; on that edge delay counter := 0 and short_flag := (sample_voltage <= SHORT_VOL, signed compare).
REQ-014 WAIT_BD: on each edge with breakdown false, delay counter increments, saturating at 16'hFFFF; with breakdown true -> DISCHARGE, counter frozen, bd_seen := 1.
REQ-015 Breakdown SHALL mean (sample_current >= BD_CUR) AND (sample_voltage <= BD_VOL); both compares signed, thresholds zero-extended to 17 bits.
REQ-016 WAIT_BD or DISCHARGE with power_on=0 -> REPORT; REPORT -> IDLE unconditionally after one cycle.
REQ-017 In REPORT: pulse_valid=1 for exactly one cycle; delay_time = counter; pulse_class = short if short_flag, else open if !bd_seen, else arc if counter < ARC_DELAY, else normal.
REQ-018 pulse_class and delay_time SHALL hold their last reported values until the next REPORT.
REQ-019 On pulse_valid, the matching class counter SHALL increment, saturating at 16'hFFFF.
REQ-020 clear_stats=1 SHALL zero all four counters on that edge; if coincident with REPORT, clear wins, the pulse is not counted, and pulse_valid still asserts.
REQ-021 is_machine=0 in any state SHALL force IDLE on that edge with no REPORT (aborted window discarded); counters hold.
REQ-022 Power_on falling and breakdown on the same WAIT_BD edge SHALL go to REPORT with bd_seen=0 (open).

Reset
REQ-023 rst_n=0 at a clk edge SHALL set state IDLE, pulse_valid 0, pulse_class 00, delay_time 0, all counters 0, short_alarm 0, internal flags 0, including mid-window (no report).

Configuration
REQ-024 Macro DISCHARGE_MONITOR_SHORT_ALARM_EN defined: short_alarm SHALL set on the REPORT giving the 4th consecutive short class, stay set until a non-short, non-aborted report, clear_stats, or reset; consecutive count saturates at 4.
REQ-025 Macro undefined: short_alarm SHALL be constant 0 and no consecutive-short logic is built.

Verification
REQ-026 Window of 50 cycles, V=80 throughout, I=0 -> pulse_valid 1 cycle after power_on falls, class 00, delay_time 50, open_cnt 1.
REQ-027 V=80, breakdown (I=20, V=25) after 300 cycles, power_on off 200 cycles later -> class 01, delay_time 300, normal_cnt 1.
REQ-028 Breakdown after 40 cycles -> class 10, delay_time 40; window starting with V=3 -> class 11 regardless of breakdown.
REQ-029 normal_cnt preloaded to FFFF via 65535 pulses (or forced) plus one more normal -> stays FFFF; clear_stats coincident with REPORT -> all counters 0, pulse_valid still 1.
REQ-030 is_machine dropped mid-DISCHARGE -> no pulse_valid, IDLE next cycle; rst_n low mid-WAIT_BD -> all outputs reset, no report.
REQ-031 With DISCHARGE_MONITOR_SHORT_ALARM_EN: 4 short windows -> short_alarm set on 4th REPORT; next normal -> cleared; without macro -> always 0.

Source files
------------

// File: rtl/discharge_monitor.sv
// Discharge pulse monitor: classifies each machining window as open, normal,
// arc or short from the breakdown delay and the gap voltage at window start,
// and keeps saturating per-class statistics.
// Optional feature: define DISCHARGE_MONITOR_SHORT_ALARM_EN to build the
// consecutive-short alarm; otherwise short_alarm is tied low.
module discharge_monitor #(
  parameter logic [15:0] BD_CUR    = 16'd15,
  parameter logic [15:0] BD_VOL    = 16'd30,
  parameter logic [15:0] SHORT_VOL = 16'd5,
  parameter logic [15:0] ARC_DELAY = 16'd100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               is_machine,
  input  logic               clear_stats,
  input  logic [1:0]         mosfet_buck1,
  input  logic [1:0]         mosfet_res1,
  input  logic               mosfet_deion,
  input  logic signed [16:0] sample_current,
  input  logic signed [16:0] sample_voltage,
  output logic               pulse_valid,
  output logic [1:0]         pulse_class,
  output logic [15:0]        delay_time,
  output logic [15:0]        open_cnt,
  output logic [15:0]        normal_cnt,
  output logic [15:0]        arc_cnt,
  output logic [15:0]        short_cnt,
  output logic               short_alarm
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned SMP_W = 17;

  localparam logic [1:0] CLS_OPEN   = 2'b00;
  localparam logic [1:0] CLS_NORMAL = 2'b01;
  localparam logic [1:0] CLS_ARC    = 2'b10;
  localparam logic [1:0] CLS_SHORT  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Thresholds are unsigned; zero-extend so the signed compares never see them as negative.
  localparam logic signed [SMP_W-1:0] BD_CUR_S    = $signed({1'b0, BD_CUR});
  localparam logic signed [SMP_W-1:0] BD_VOL_S    = $signed({1'b0, BD_VOL});
  localparam logic signed [SMP_W-1:0] SHORT_VOL_S = $signed({1'b0, SHORT_VOL});

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BD   = 2'd1,
    DISCHARGE = 2'd2,
    REPORT    = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] delay_cnt;
  logic             short_flag;
  logic             bd_seen;

  logic       power_on_c;
  logic       breakdown_c;
  logic       short_start_c;
  logic       report_c;
  logic [1:0] report_class_c;
  logic       unused_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Bottom switches and the deionisation switch do not take part in classification.
  assign unused_c = &{1'b0, mosfet_deion, mosfet_buck1[0], mosfet_res1[0]};

  // Window qualifiers straight from the unregistered inputs.
  assign power_on_c    = mosfet_buck1[1] | mosfet_res1[1];
  assign breakdown_c   = (sample_current >= BD_CUR_S) && (sample_voltage <= BD_VOL_S);
  assign short_start_c = (sample_voltage <= SHORT_VOL_S);

  // A window ends with a report when power drops while machining stays enabled.
  assign report_c = ((state == WAIT_BD) || (state == DISCHARGE)) && is_machine && !power_on_c;

  // Class of the window being closed; bd_seen is only ever set on entry to DISCHARGE.
  always_comb begin
    report_class_c = CLS_NORMAL;
    if (short_flag)                  report_class_c = CLS_SHORT;
    else if (!bd_seen)               report_class_c = CLS_OPEN;
    else if (delay_cnt < ARC_DELAY)  report_class_c = CLS_ARC;
  end

  // Window FSM with registered report outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      delay_cnt   <= '0;
      short_flag  <= 1'b0;
      bd_seen     <= 1'b0;
      pulse_valid <= 1'b0;
      pulse_class <= CLS_OPEN;
      delay_time  <= '0;
    end else begin
      pulse_valid <= 1'b0;
      if (report_c) begin
        pulse_valid <= 1'b1;
        pulse_class <= report_class_c;
        delay_time  <= delay_cnt;
      end
      case (state)
        IDLE: begin
          if (is_machine && power_on_c) begin
            state      <= WAIT_BD;
            delay_cnt  <= '0;
            short_flag <= short_start_c;
            bd_seen    <= 1'b0;
          end
        end
        WAIT_BD: begin
          if (!is_machine) begin
            state <= IDLE;
          end else if (!power_on_c) begin
            state <= REPORT;
          end else if (breakdown_c) begin
            state   <= DISCHARGE;
            bd_seen <= 1'b1;
          end else begin
            delay_cnt <= sat_inc(delay_cnt);
          end
        end
        DISCHARGE: begin
          if (!is_machine)      state <= IDLE;
          else if (!power_on_c) state <= REPORT;
        end
        REPORT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Per-class statistics; a clear on the counting edge drops that pulse.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_stats) begin
      open_cnt   <= '0;
      normal_cnt <= '0;
      arc_cnt    <= '0;
      short_cnt  <= '0;
    end else if (pulse_valid) begin
      case (pulse_class)
        CLS_OPEN:   open_cnt   <= sat_inc(open_cnt);
        CLS_NORMAL: normal_cnt <= sat_inc(normal_cnt);
        CLS_ARC:    arc_cnt    <= sat_inc(arc_cnt);
        default:    short_cnt  <= sat_inc(short_cnt);
      endcase
    end
  end

`ifdef DISCHARGE_MONITOR_SHORT_ALARM_EN
  logic [2:0] short_run;

  // Alarm after four consecutive short reports; any other report re-arms it.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_stats) begin
      short_run   <= '0;
      short_alarm <= 1'b0;
    end else if (report_c) begin
      if (report_class_c == CLS_SHORT) begin
        if (short_run < 3'd4) short_run <= short_run + 3'd1;
        if (short_run >= 3'd3) short_alarm <= 1'b1;
      end else begin
        short_run   <= '0;
        short_alarm <= 1'b0;
      end
    end
  end
`else
  assign short_alarm = 1'b0;
`endif

endmodule
